// File: rtl/bcd_digit_entry.sv
// Two-digit BCD entry (tens, then ones) converted to 7-bit binary by repeated +10.
// Optional seven-segment echo of the entered digits under macro SEG_ECHO_EN.
module bcd_digit_entry (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic [3:0] digit,
   input  logic       digit_valid,
   output logic       in_ready,
   output logic [6:0] bin,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       err
`ifdef SEG_ECHO_EN
   ,
   output logic [6:0] hex1,
   output logic [6:0] hex0
`endif
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ONES = 2'd1,
      CONVERT   = 2'd2,
      HOLD      = 2'd3
   } state_t;

   state_t     state, state_n;
   logic [3:0] tens, tens_n;
   logic [3:0] ones, ones_n;
   logic [3:0] count, count_n;
   logic [6:0] acc, acc_n;
   logic       err_n;
   logic       taking;
   logic       is_bcd;

   assign taking    = (state == IDLE) || (state == WAIT_ONES);
   assign is_bcd    = (digit <= 4'd9);
   assign in_ready  = taking && !reset;
   assign out_valid = (state == HOLD);
   assign bin       = (state == HOLD) ? acc : 7'd0;

`ifdef SEG_ECHO_EN
   logic [6:0] hex1_n, hex0_n;

   // Active-low segments, bit0 = a .. bit6 = g.
   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'h7F;
      endcase
   endfunction
`endif

   always_comb begin
      state_n = state;
      tens_n  = tens;
      ones_n  = ones;
      count_n = count;
      acc_n   = acc;
      err_n   = 1'b0;
`ifdef SEG_ECHO_EN
      hex1_n  = hex1;
      hex0_n  = hex0;
`endif
      case (state)
         IDLE: begin
            if (digit_valid) begin
               if (is_bcd) begin
                  tens_n  = digit;
                  state_n = WAIT_ONES;
`ifdef SEG_ECHO_EN
                  hex1_n  = seg(digit);
                  hex0_n  = 7'h7F;
`endif
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         WAIT_ONES: begin
            if (digit_valid) begin
               if (is_bcd) begin
                  ones_n  = digit;
                  acc_n   = {3'b000, digit};
                  count_n = 4'd0;
                  state_n = CONVERT;
`ifdef SEG_ECHO_EN
                  hex0_n  = seg(digit);
`endif
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         CONVERT: begin
            // One +10 per edge; the final edge only moves to HOLD, giving tens+1 latency.
            if (count == tens) begin
               state_n = HOLD;
            end else begin
               acc_n   = acc + 7'd10;
               count_n = count + 4'd1;
            end
         end
         HOLD: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      if (clear) begin
         state_n = IDLE;
         tens_n  = 4'd0;
         ones_n  = 4'd0;
         count_n = 4'd0;
         acc_n   = 7'd0;
         err_n   = 1'b0;
`ifdef SEG_ECHO_EN
         hex1_n  = 7'h7F;
         hex0_n  = 7'h7F;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         tens  <= 4'd0;
         ones  <= 4'd0;
         count <= 4'd0;
         acc   <= 7'd0;
         err   <= 1'b0;
`ifdef SEG_ECHO_EN
         hex1  <= 7'h7F;
         hex0  <= 7'h7F;
`endif
      end else begin
         state <= state_n;
         tens  <= tens_n;
         ones  <= ones_n;
         count <= count_n;
         acc   <= acc_n;
         err   <= err_n;
`ifdef SEG_ECHO_EN
         hex1  <= hex1_n;
         hex0  <= hex0_n;
`endif
      end
   end

endmodule
